elevator_request_scheduler: RTL and testbench

SCAN ("elevator algorithm") request scheduler placed in front of `Elevator_Control`. It merges floor calls from the cabin panel and the hall panels into a pending-floor bitmap. It then drives `Elevator_Control`'s `req_floor` with the next floor to serve in the current travel direction, and clears each call when the car opens its doors at that floor.

---
 rtl/elevator_pkg.sv | 18 +
 rtl/floor_scan_find.sv | 36 +++
 rtl/elevator_request_scheduler.sv | 153 +++++++++++++++
 tb/tb_elevator_request_scheduler.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared types and defaults for the elevator request scheduler
package elevator_pkg;

  localparam int DEF_FLOOR_W    = 7;
  localparam int DEF_NUM_FLOORS = 64;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SERVE_UP   = 2'd1,
    SERVE_DOWN = 2'd2,
    DWELL      = 2'd3
  } sched_state_t;

  typedef logic dir_t;
  localparam dir_t UP   = 1'b1;
  localparam dir_t DOWN = 1'b0;

endpackage

// File: rtl/floor_scan_find.sv
// rtl/floor_scan_find.sv - nearest pending floor above and below the car
module floor_scan_find
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = DEF_NUM_FLOORS,
  parameter int FLOOR_W    = DEF_FLOOR_W
) (
  input  logic [NUM_FLOORS-1:0] bitmap_i,
  input  logic [FLOOR_W-1:0]    cur_floor_i,
  output logic                  above_valid_o,
  output logic [FLOOR_W-1:0]    above_floor_o,
  output logic                  below_valid_o,
  output logic [FLOOR_W-1:0]    below_floor_o
);

  always_comb begin
    above_valid_o = 1'b0;
    above_floor_o = '0;
    below_valid_o = 1'b0;
    below_floor_o = '0;
    // Opposite scan orders: the last hit is the nearest floor in each direction.
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (bitmap_i[i] && (FLOOR_W'(i) > cur_floor_i)) begin
        above_valid_o = 1'b1;
        above_floor_o = FLOOR_W'(i);
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (bitmap_i[i] && (FLOOR_W'(i) < cur_floor_i)) begin
        below_valid_o = 1'b1;
        below_floor_o = FLOOR_W'(i);
      end
    end
  end

endmodule

// File: rtl/elevator_request_scheduler.sv
// rtl/elevator_request_scheduler.sv - SCAN scheduler merging cab/hall calls into req_floor
module elevator_request_scheduler
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = DEF_NUM_FLOORS,
  parameter int FLOOR_W    = DEF_FLOOR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cab_valid,
  input  logic [FLOOR_W-1:0]    cab_floor,
  output logic                  cab_ready,
  input  logic                  hall_valid,
  input  logic [FLOOR_W-1:0]    hall_floor,
  output logic                  hall_ready,
  input  logic [FLOOR_W-1:0]    cur_floor,
  input  logic                  door_open,
  output logic [FLOOR_W-1:0]    req_floor,
  output logic                  req_valid,
  output logic                  dir_up,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  call_drop
);

  sched_state_t          state_q, state_d;
  logic [FLOOR_W-1:0]    req_floor_q, req_floor_d;
  logic                  req_valid_q, req_valid_d;
  dir_t                  dir_up_q, dir_up_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic                  call_drop_q, call_drop_d;
  logic                  prio_hall_q;
  logic                  door_q;

  logic                  acc_fire;
  logic [FLOOR_W-1:0]    acc_floor;
  logic [NUM_FLOORS-1:0] set_mask, here_mask;
  logic                  at_floor, door_rise, door_fall;
  logic                  above_valid, below_valid;
  logic [FLOOR_W-1:0]    above_floor, below_floor;

  assign cab_ready  = reset & cab_valid & (~hall_valid | ~prio_hall_q);
  assign hall_ready = reset & hall_valid & (~cab_valid | prio_hall_q);
  assign acc_fire   = cab_ready | hall_ready;
  assign acc_floor  = cab_ready ? cab_floor : hall_floor;
  assign door_rise  = door_open & ~door_q;
  assign door_fall  = ~door_open & door_q;

  always_comb begin
    set_mask  = '0;
    here_mask = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      set_mask[i]  = acc_fire && (acc_floor == FLOOR_W'(i));
      here_mask[i] = (cur_floor == FLOOR_W'(i));
    end
  end

  // Clear after set so a door opening at the called floor serves that call.
  assign pending_d   = (pending_q | set_mask) & ~(door_rise ? here_mask : '0);
  assign call_drop_d = acc_fire && (int'(acc_floor) >= NUM_FLOORS);
  assign at_floor    = |(pending_q & here_mask);

  floor_scan_find #(.NUM_FLOORS(NUM_FLOORS), .FLOOR_W(FLOOR_W)) u_scan (
    .bitmap_i      (pending_q),
    .cur_floor_i   (cur_floor),
    .above_valid_o (above_valid),
    .above_floor_o (above_floor),
    .below_valid_o (below_valid),
    .below_floor_o (below_floor)
  );

  always_comb begin
    state_d     = state_q;
    req_floor_d = req_floor_q;
    req_valid_d = req_valid_q;
    dir_up_d    = dir_up_q;
    case (state_q)
      IDLE: begin
        req_valid_d = 1'b0;
        if (|pending_q) begin
          if (at_floor) begin
            state_d     = DWELL;
            req_floor_d = cur_floor;
          end else if (above_valid) begin
            state_d = SERVE_UP;    req_floor_d = above_floor; req_valid_d = 1'b1; dir_up_d = UP;
          end else begin
            state_d = SERVE_DOWN;  req_floor_d = below_floor; req_valid_d = 1'b1; dir_up_d = DOWN;
          end
        end
      end
      SERVE_UP, SERVE_DOWN: begin
        // Once the car is level with a pending floor it holds there until the doors open.
        if (door_rise) begin
          state_d = DWELL;  req_floor_d = cur_floor;  req_valid_d = 1'b0;
        end else if (at_floor) begin
          req_floor_d = cur_floor;
        end else if (state_q == SERVE_UP && above_valid) begin
          req_floor_d = above_floor;
        end else if (state_q == SERVE_DOWN && below_valid) begin
          req_floor_d = below_floor;
        end else if (above_valid) begin
          state_d = SERVE_UP;    req_floor_d = above_floor; dir_up_d = UP;
        end else if (below_valid) begin
          state_d = SERVE_DOWN;  req_floor_d = below_floor; dir_up_d = DOWN;
        end else begin
          state_d = IDLE;        req_valid_d = 1'b0;
        end
      end
      DWELL: begin
        req_floor_d = cur_floor;
        req_valid_d = 1'b0;
        if (door_fall) begin
          if ((dir_up_q && above_valid) || (!dir_up_q && !below_valid && above_valid)) begin
            state_d = SERVE_UP;    req_floor_d = above_floor; req_valid_d = 1'b1; dir_up_d = UP;
          end else if (below_valid) begin
            state_d = SERVE_DOWN;  req_floor_d = below_floor; req_valid_d = 1'b1; dir_up_d = DOWN;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      req_floor_q <= '0;
      req_valid_q <= 1'b0;
      dir_up_q    <= DOWN;
      pending_q   <= '0;
      call_drop_q <= 1'b0;
      prio_hall_q <= 1'b0;
      door_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_floor_q <= req_floor_d;
      req_valid_q <= req_valid_d;
      dir_up_q    <= dir_up_d;
      pending_q   <= pending_d;
      call_drop_q <= call_drop_d;
      door_q      <= door_open;
      if (acc_fire) prio_hall_q <= cab_ready;
    end
  end

  assign req_floor = req_floor_q;
  assign req_valid = req_valid_q;
  assign dir_up    = dir_up_q;
  assign pending   = pending_q;
  assign call_drop = call_drop_q;

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// tb/tb_elevator_request_scheduler.sv - scoreboard bench for elevator_request_scheduler
module tb_elevator_request_scheduler;

  localparam int NF = 64;
  localparam int FW = 7;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cab_valid = 1'b0, hall_valid = 1'b0, door_open = 1'b0;
  logic [FW-1:0] cab_floor = '0, hall_floor = '0, cur_floor = '0;
  logic          cab_ready, hall_ready, req_valid, dir_up, call_drop;
  logic [FW-1:0] req_floor;
  logic [NF-1:0] pending;

  always #5 clk = ~clk;

  elevator_request_scheduler #(.NUM_FLOORS(NF), .FLOOR_W(FW)) dut (
    .clk(clk), .reset(reset),
    .cab_valid(cab_valid), .cab_floor(cab_floor), .cab_ready(cab_ready),
    .hall_valid(hall_valid), .hall_floor(hall_floor), .hall_ready(hall_ready),
    .cur_floor(cur_floor), .door_open(door_open),
    .req_floor(req_floor), .req_valid(req_valid), .dir_up(dir_up),
    .pending(pending), .call_drop(call_drop)
  );

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [FW-1:0] floor;
    logic          dir;
  } tgt_t;

  tgt_t          exp_q[$];
  tgt_t          mon_e;
  logic          mon_prev_valid = 1'b0;
  logic [FW-1:0] mon_prev_floor = '0;
  logic          mon_prev_dir = 1'b0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  function automatic logic [NF-1:0] bit_of(input int f);
    return {{(NF-1){1'b0}}, 1'b1} << f;
  endfunction

  task automatic push_tgt(input int f, input logic d);
    tgt_t t;
    t.floor = FW'(f);
    t.dir   = d;
    exp_q.push_back(t);
  endtask

  // Monitor: every new target the DUT presents must match the next expected one.
  initial begin
    forever begin
      @(negedge clk);
      if (reset && req_valid &&
          (!mon_prev_valid || req_floor != mon_prev_floor || dir_up != mon_prev_dir)) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_target: got floor %0d dir %0d, none expected", req_floor, dir_up);
        end else begin
          mon_e = exp_q.pop_front();
          chk("target_floor", req_floor, mon_e.floor);
          chk("target_dir", dir_up, mon_e.dir);
        end
      end
      mon_prev_valid = reset & req_valid;
      mon_prev_floor = req_floor;
      mon_prev_dir   = dir_up;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic call(input logic is_cab, input int f);
    int n = 0;
    if (is_cab) begin cab_valid = 1'b1; cab_floor = FW'(f); end
    else begin hall_valid = 1'b1; hall_floor = FW'(f); end
    @(negedge clk);
    while (!(is_cab ? cab_ready : hall_ready) && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (n >= 20) begin
      tests++;
      fails++;
      $display("FAIL call_timeout: floor %0d never accepted", f);
    end
    @(posedge clk);
    #1;
    cab_valid  = 1'b0;
    hall_valid = 1'b0;
  endtask

  task automatic serve_at(input int f);
    cur_floor = FW'(f);
    tick();
    door_open = 1'b1;
    tick();
    @(negedge clk);
    chk("door_clear", pending & bit_of(f), 0);
    chk("dwell_req_valid", req_valid, 0);
    tick();
    door_open = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    // Reset state, with a cab call held to confirm readies stay low.
    cab_valid = 1'b1;
    cab_floor = 7'd5;
    repeat (3) @(negedge clk);
    chk("rst_req_floor", req_floor, 0);
    chk("rst_req_valid", req_valid, 0);
    chk("rst_dir_up", dir_up, 0);
    chk("rst_pending", pending, 0);
    chk("rst_call_drop", call_drop, 0);
    chk("rst_cab_ready", cab_ready, 0);
    chk("rst_hall_ready", hall_ready, 0);
    tick();
    cab_valid = 1'b0;
    reset = 1'b1;
    tick();

    // First call from floor 0: two-cycle latency to req_valid.
    cur_floor = 7'd0;
    push_tgt(25, 1'b1);
    call(1'b1, 25);
    @(negedge clk);
    chk("pend_after_call", pending, bit_of(25));
    chk("req_valid_latency", req_valid, 0);
    @(negedge clk);
    chk("first_req_valid", req_valid, 1);
    chk("first_req_floor", req_floor, 25);
    chk("first_dir_up", dir_up, 1);

    // Nearer hall call retargets mid-travel, then the sweep resumes to 25.
    tick();
    cur_floor = 7'd5;
    tick();
    push_tgt(12, 1'b1);
    call(1'b0, 12);
    @(negedge clk);
    @(negedge clk);
    chk("retarget_12", req_floor, 12);
    tick();
    push_tgt(25, 1'b1);
    serve_at(12);
    @(negedge clk);
    chk("resume_25_floor", req_floor, 25);
    chk("resume_25_valid", req_valid, 1);
    chk("pend_only_25", pending, bit_of(25));
    tick();
    serve_at(25);
    @(negedge clk);
    chk("idle_pending", pending, 0);
    chk("idle_req_valid", req_valid, 0);
    chk("idle_dir_hold", dir_up, 1);

    // Going up from 10 with {37, 3}: 37 first, then reverse to 3.
    tick();
    cur_floor = 7'd10;
    push_tgt(37, 1'b1);
    call(1'b1, 37);
    call(1'b0, 3);
    @(negedge clk);
    @(negedge clk);
    chk("pend_37_3", pending, bit_of(37) | bit_of(3));
    tick();
    push_tgt(3, 1'b0);
    serve_at(37);
    @(negedge clk);
    chk("reverse_dir", dir_up, 0);
    chk("reverse_floor", req_floor, 3);
    tick();
    serve_at(3);
    @(negedge clk);
    chk("down_idle_pending", pending, 0);
    chk("down_dir_hold", dir_up, 0);

    // Both sources valid every cycle: cab granted first, then hall.
    tick();
    cur_floor = 7'd20;
    tick();
    push_tgt(4, 1'b0);
    push_tgt(9, 1'b0);
    cab_valid = 1'b1;  cab_floor = 7'd4;
    hall_valid = 1'b1; hall_floor = 7'd9;
    @(negedge clk);
    chk("rr1_cab_ready", cab_ready, 1);
    chk("rr1_hall_ready", hall_ready, 0);
    tick();
    @(negedge clk);
    chk("rr2_cab_ready", cab_ready, 0);
    chk("rr2_hall_ready", hall_ready, 1);
    tick();
    cab_valid = 1'b0;
    hall_valid = 1'b0;
    @(negedge clk);
    chk("rr_pending", pending, bit_of(4) | bit_of(9));
    tick();
    push_tgt(4, 1'b0);
    serve_at(9);
    serve_at(4);

    // Out-of-range call is dropped; a call at the car's floor goes straight to DWELL.
    call(1'b1, 100);
    @(negedge clk);
    chk("drop_pulse", call_drop, 1);
    chk("drop_pending", pending, 0);
    @(negedge clk);
    chk("drop_pulse_end", call_drop, 0);
    tick();
    call(1'b1, 4);
    @(negedge clk);
    chk("here_pending", pending, bit_of(4));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("here_no_req_valid", req_valid, 0);
    end
    tick();
    serve_at(4);
    @(negedge clk);
    chk("here_served", pending, 0);

    // Reset during SERVE_UP with three calls outstanding.
    tick();
    cur_floor = 7'd0;
    push_tgt(10, 1'b1);
    call(1'b1, 10);
    call(1'b0, 20);
    call(1'b1, 30);
    repeat (3) @(negedge clk);
    chk("pre_rst_pending", pending, bit_of(10) | bit_of(20) | bit_of(30));
    chk("pre_rst_valid", req_valid, 1);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_pending", pending, 0);
    chk("mid_rst_valid", req_valid, 0);
    chk("mid_rst_floor", req_floor, 0);
    chk("mid_rst_dir", dir_up, 0);
    tick();
    reset = 1'b1;
    tick();

    // After reset the grant pointer favours cab again.
    push_tgt(15, 1'b1);
    cab_valid = 1'b1;  cab_floor = 7'd15;
    hall_valid = 1'b1; hall_floor = 7'd40;
    @(negedge clk);
    chk("post_rst_cab_first", cab_ready, 1);
    chk("post_rst_hall_wait", hall_ready, 0);
    tick();
    cab_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_hall_ready", hall_ready, 1);
    tick();
    hall_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_floor", req_floor, 15);
    chk("post_rst_pending", pending, bit_of(15) | bit_of(40));
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
